// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB requester, the completer-side
// register interfaces and benches.
//   apb_state_e      : transfer phase encoding (IDLE / SETUP / ACCESS)
//   apb_rsp_status_t : status fields that accompany every response
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic err;
        logic timeout;
    } apb_rsp_status_t;

endpackage

// File: rtl/apb_master.sv
// apb_master: APB4 requester. Turns a valid/ready command port into
// APB SETUP/ACCESS transfers and returns one registered single-cycle
// response per command. A wait-state timeout aborts a transfer whose
// completer holds pready low too long.
//
// Ports
//   pclk, prst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (accepted at posedge when both high)
//   cmd_write/addr/wdata/strb : command payload
//   rsp_valid             : one-cycle response pulse
//   rsp_rdata/err/timeout : response payload, held until the next response
//   psel/penable/pwrite/paddr/pwdata/pstrb : APB request signals
//   prdata/pready/pslverr : APB completer signals (only looked at in ACCESS)
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    prst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    // Last counter value before abort: the abort edge is the one that
    // ends the TIMEOUT_CYCLES-th ACCESS cycle with pready low.
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int unsigned CNT_W   = (TO_LAST < 2) ? 1 : $clog2(TO_LAST + 1);

    apb_state_e       state_q, state_d;
    logic             ready_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             accept, complete, abort;
    apb_rsp_status_t  status_q;

    // Next state and transfer events
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // pready wins over a timeout expiring on the same edge
                if (pready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_W'(TO_LAST))) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_ready is registered so it stays low throughout reset and only
    // rises on the first clock after release.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_d == IDLE);
        end
    end

    // Counts ACCESS cycles with pready low; cleared outside ACCESS
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Request payload: loaded only on acceptance, so it holds its last
    // value between transfers.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : '0;
        end
    end

    // Response registers
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            status_q  <= '0;
        end else begin
            rsp_valid <= complete | abort;
            if (complete) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                status_q  <= '{err: pslverr, timeout: 1'b0};
            end else if (abort) begin
                rsp_rdata <= '0;
                status_q  <= '{err: 1'b1, timeout: 1'b1};
            end
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_err     = status_q.err;
    assign rsp_timeout = status_q.timeout;
    assign psel        = (state_q != IDLE);
    assign penable     = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
    import apb_pkg::*;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;    // ACCESS cycles with pready low before pready (>=16 never)
        logic [31:0] sdata;    // completer read data
        logic        serr;     // completer pslverr at pready
        logic [31:0] x_rdata;
        logic        x_err;
        logic        x_to;
        logic [3:0]  x_pstrb;
        int          x_psel;   // cycles psel high for this transfer
    } vec_t;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial forever #5 pclk = ~pclk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_rsp = 0;
    int   cyc   = 0;
    vec_t q[$];
    logic late_pready = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completer model: decides pready/prdata/pslverr for the next edge.
    // Off-target values are driven while waiting so early sampling shows up.
    initial begin
        int wcnt;
        wcnt = 0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (psel && penable && q.size() > 0) begin
                if (wcnt == q[0].waits) begin
                    pready = 1'b1; prdata = q[0].sdata; pslverr = q[0].serr;
                end else begin
                    pready = 1'b0; prdata = ~q[0].sdata; pslverr = ~q[0].serr;
                end
                wcnt++;
            end else begin
                wcnt = 0; pready = late_pready; prdata = 32'hFFFF_FFFF; pslverr = late_pready;
            end
        end
    end

    // Monitor: checks the APB request at SETUP, stability in ACCESS,
    // and pops the scoreboard on every response.
    initial begin
        int psel_cnt, pen_cnt;
        logic [11:0] a_snap;
        logic [31:0] d_snap;
        vec_t e;
        psel_cnt = 0; pen_cnt = 0; a_snap = '0; d_snap = '0;
        forever begin
            @(negedge pclk);
            if (!prst_n) begin
                psel_cnt = 0; pen_cnt = 0;
            end else begin
                if (psel) begin
                    psel_cnt++;
                    if (!penable) begin
                        if (q.size() == 0) chk("setup_without_cmd", 1, 0);
                        else begin
                            chk("setup_paddr", paddr, q[0].addr);
                            chk("setup_pwrite", pwrite, q[0].wr);
                            chk("setup_pstrb", pstrb, q[0].x_pstrb);
                            if (q[0].wr) chk("setup_pwdata", pwdata, q[0].wdata);
                        end
                        a_snap = paddr; d_snap = pwdata;
                    end else begin
                        pen_cnt++;
                        chk("access_paddr_stable", paddr, a_snap);
                        chk("access_pwdata_stable", pwdata, d_snap);
                    end
                end
                if (rsp_valid) begin
                    n_rsp++;
                    if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.x_rdata);
                        chk("rsp_err", rsp_err, e.x_err);
                        chk("rsp_timeout", rsp_timeout, e.x_to);
                        chk("psel_cycles", psel_cnt, e.x_psel);
                        chk("penable_cycles", pen_cnt, e.x_psel - 1);
                        chk("psel_low_in_rsp", psel, 0);
                    end
                    psel_cnt = 0; pen_cnt = 0;
                end
            end
        end
    end

    // Present v starting at a negedge; returns after the accepting posedge.
    task automatic send(input vec_t v, output int acc_cyc);
        int guard;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        guard = 0;
        acc_cyc = -1;
        while (!cmd_ready && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
        end else begin
            @(posedge pclk);
            q.push_back(v);
            acc_cyc = cyc;
            @(negedge pclk);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        chk("drain_scoreboard", q.size(), 0);
    endtask

    vec_t tbl[9];
    int   acc[9];

    initial begin
        int dummy, base;
        tbl[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF,   0, 32'h0BAD0BAD, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF,  2};
        tbl[1] = '{1'b0, 12'h020, 32'h0,        4'hF,   3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 4'h0,  5};
        tbl[2] = '{1'b0, 12'h030, 32'h0,        4'h3,   0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0,  2};
        tbl[3] = '{1'b1, 12'h03C, 32'h11223344, 4'h5,   1, 32'h55555555, 1'b1, 32'h0,        1'b1, 1'b0, 4'h5,  3};
        tbl[4] = '{1'b0, 12'h040, 32'h0,        4'h0,  15, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0, 4'h0, 17};
        tbl[5] = '{1'b0, 12'h044, 32'h0,        4'h0, 255, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b1, 1'b1, 4'h0, 17};
        tbl[6] = '{1'b1, 12'h000, 32'h00000001, 4'hF,   0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4'hF,  2};
        tbl[7] = '{1'b1, 12'h004, 32'h00000002, 4'hF,   0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4'hF,  2};
        tbl[8] = '{1'b1, 12'h008, 32'h00000003, 4'hF,   0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4'hF,  2};

        prst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        repeat (3) @(negedge pclk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_paddr", paddr, 0);
        prst_n = 1'b1;
        @(negedge pclk);
        chk("ready_after_release", cmd_ready, 1);

        // Table: commands presented back-to-back with cmd_valid held high
        for (int i = 0; i < 9; i++) send(tbl[i], acc[i]);
        cmd_valid = 1'b0;
        drain();
        for (int i = 7; i < 9; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
        chk("rsp_count_table", n_rsp, 9);

        // Timeout followed by a late pready: no extra response
        base = n_rsp;
        send(tbl[5], dummy);
        cmd_valid = 1'b0;
        drain();
        late_pready = 1'b1;
        repeat (5) @(negedge pclk);
        late_pready = 1'b0;
        chk("late_pready_no_rsp", n_rsp, base + 1);
        chk("idle_psel_low", psel, 0);

        // Reset during ACCESS wait states
        base = n_rsp;
        send(tbl[5], dummy);
        cmd_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!penable && guard < 10) begin @(negedge pclk); guard++; end
            chk("reached_access", penable, 1);
        end
        repeat (4) @(negedge pclk);
        #2 prst_n = 1'b0;
        #1;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        q.delete();
        repeat (2) @(negedge pclk);
        prst_n = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("ready_first_clk_after_rst", cmd_ready, 1);
        repeat (25) @(negedge pclk);
        chk("no_stale_rsp", n_rsp, base);

        // Normal operation resumes
        send(tbl[0], dummy);
        cmd_valid = 1'b0;
        drain();
        chk("rsp_count_final", n_rsp, base + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB4 requester (initiator) that turns a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Acts as the counterpart of the team's APB slave-side register interfaces: drives psel/penable/paddr/pwrite/pwdata/pstrb and samples prdata/pready/pslverr.
- Returns one response per command on a registered, single-cycle response port.
- Includes a wait-state timeout so a hung completer cannot stall the bus indefinitely.

Parameters:
- ADDR_WIDTH, 12, width of cmd_addr/paddr.
- DATA_WIDTH, 32, width of data buses; pstrb width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  input  1  APB clock.
- prst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  transfer address.
- cmd_wdata  input  DATA_WIDTH  write data.
- cmd_strb  input  DATA_WIDTH/8  write byte strobes.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  output  1  pslverr sampled at completion, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pstrb  output  DATA_WIDTH/8  APB strobes.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  completer ready.
- pslverr  input  1  completer error.

Behaviour:
- Reset (async, prst_n = 0): FSM to IDLE; every output 0, including cmd_ready; timeout counter 0.
- Reset mid-transfer abandons the transfer immediately with no response. After release, cmd_ready is 1 on the first clock.
- IDLE:
  - cmd_ready = 1; psel = penable = 0.
  - On handshake: register cmd_write, cmd_addr, cmd_wdata and strobes onto pwrite/paddr/pwdata/pstrb; go to SETUP.
  - For reads, pstrb is forced to 0.
- SETUP: exactly one cycle; psel = 1, penable = 0, cmd_ready = 0; go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; all address, control and data outputs held stable.
  - Count cycles with pready = 0.
  - pready = 1 at a posedge completes the transfer:
    - Capture prdata into rsp_rdata (reads only, otherwise 0).
    - Capture pslverr into rsp_err; rsp_timeout = 0.
    - Go to IDLE.
  - Timeout: if TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with pready still 0:
    - Abort and go to IDLE.
    - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 arrives on the same edge as the timeout threshold, pready wins (normal completion).
- Response:
  - rsp_valid is registered and high for exactly the one cycle after completion/abort; the FSM is in IDLE during that cycle.
  - rsp_rdata/rsp_err/rsp_timeout hold their values until the next response.
  - There is no response backpressure.
- Throughput:
  - Back-to-back commands are allowed: a new command can be accepted in the rsp_valid cycle.
  - Minimum 3 cycles per transfer: accept, SETUP, ACCESS.
- Between transfers: psel = penable = 0; paddr/pwdata/pwrite keep their last values, with no toggling.
- pready/pslverr/prdata are ignored outside ACCESS, including a late pready after a timeout.
- Latency: command accepted at edge T0 → SETUP T0–T1 → ACCESS from T1; with zero wait states, completion at T2 and rsp_valid high during T2–T3.

Decomposition:
- Shared package apb_pkg: state encoding constants (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2) and the response-field grouping, for reuse by the slave side and by benches.
- Single flat module; the timeout counter is inline, no sub-module.

Test Plan:
- Write, zero wait: cmd addr 0x010, wdata 0xDEADBEEF, strb 0xF → psel high 2 cycles, penable high 1 cycle, pstrb = 0xF, rsp_valid 1 cycle, rsp_err = 0, rsp_rdata = 0.
- Read with 3 wait states: addr 0x020, completer returns 0x12345678 after pready low for 3 ACCESS cycles → paddr stable 5 cycles, pstrb = 0, rsp_rdata = 0x12345678.
- Slave error: read with pslverr = 1 at pready → rsp_err = 1, rsp_timeout = 0.
- Timeout: TIMEOUT_CYCLES = 16, pready tied 0 → psel drops after 16 ACCESS cycles, rsp_err = 1, rsp_timeout = 1; a later pready produces no response.
- Back-to-back: cmd_valid held high for writes to 0x000, 0x004, 0x008 → each accepted in its rsp_valid/IDLE cycle, 3-cycle spacing, three responses in order.
- Reset mid-ACCESS: prst_n low during wait states → psel/penable/cmd_ready/rsp_valid drop immediately; cmd_ready = 1 on the first clock after release; no stale response.
